ad9361_phase_cal: RTL

// - Measures the carrier phase of receive channels 1..3 relative to channel 0 over 2^LOG2_N

---
 rtl/ad9361_phase_cal_if.sv | 45 ++++
 rtl/ad9361_phase_cal.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ad9361_phase_cal_if.sv
// Sample, control and result bundle between the four-channel receive path and the phase calibrator.
interface ad9361_phase_cal_if #(
  parameter int ARG_BIT        = 16,
  parameter int WAVE_BIT_WIDTH = 12
);
  logic start;
  logic busy;
  logic done;

  logic valid_ci_0;
  logic valid_ci_1;
  logic valid_ci_2;
  logic valid_ci_3;

  logic signed [WAVE_BIT_WIDTH-1:0] data_ci_i0;
  logic signed [WAVE_BIT_WIDTH-1:0] data_ci_q0;
  logic signed [WAVE_BIT_WIDTH-1:0] data_ci_i1;
  logic signed [WAVE_BIT_WIDTH-1:0] data_ci_q1;
  logic signed [WAVE_BIT_WIDTH-1:0] data_ci_i2;
  logic signed [WAVE_BIT_WIDTH-1:0] data_ci_q2;
  logic signed [WAVE_BIT_WIDTH-1:0] data_ci_i3;
  logic signed [WAVE_BIT_WIDTH-1:0] data_ci_q3;

  logic signed [ARG_BIT-1:0] arg_out_1;
  logic signed [ARG_BIT-1:0] arg_out_2;
  logic signed [ARG_BIT-1:0] arg_out_3;

  modport master (
    output start,
    output valid_ci_0, valid_ci_1, valid_ci_2, valid_ci_3,
    output data_ci_i0, data_ci_q0, data_ci_i1, data_ci_q1,
    output data_ci_i2, data_ci_q2, data_ci_i3, data_ci_q3,
    input  busy, done,
    input  arg_out_1, arg_out_2, arg_out_3
  );

  modport slave (
    input  start,
    input  valid_ci_0, valid_ci_1, valid_ci_2, valid_ci_3,
    input  data_ci_i0, data_ci_q0, data_ci_i1, data_ci_q1,
    input  data_ci_i2, data_ci_q2, data_ci_i3, data_ci_q3,
    output busy, done,
    output arg_out_1, arg_out_2, arg_out_3
  );
endinterface

// File: rtl/ad9361_phase_cal.sv
// Measures the phase of channels 1..3 against channel 0 by accumulating x_k*conj(x0)
// over 2^LOG2_N samples, then resolving each sum to an alignment angle with a shared CORDIC.
module ad9361_phase_cal #(
  parameter int ARG_BIT        = 16,
  parameter int WAVE_BIT_WIDTH = 12,
  parameter int LOG2_N         = 10
) (
  input logic clk,
  input logic rst_n,
  ad9361_phase_cal_if.slave bus
);

  localparam int PW    = 2 * WAVE_BIT_WIDTH + 1;
  localparam int ACC_W = PW + LOG2_N;
  localparam int CW    = ACC_W + 2;
  localparam int SW    = $clog2(ARG_BIT + 1);

  localparam logic [LOG2_N:0] N_SAMPLES = {1'b1, {LOG2_N{1'b0}}};

  // Arctangent table is held at 16-bit angle scale and rescaled to ARG_BIT.
  localparam int          ATAN_SL  = (ARG_BIT > 16) ? ARG_BIT - 16 : 0;
  localparam int          ATAN_SR  = (ARG_BIT < 16) ? 16 - ARG_BIT : 0;
  localparam logic [31:0] ATAN_RND = (32'd1 << ATAN_SR) >> 1;

  typedef enum logic [2:0] {IDLE, ACCUM, VEC1, VEC2, VEC3} state_t;

  state_t                    state;
  logic [LOG2_N:0]           cnt;
  logic [SW-1:0]             step;
  logic signed [ACC_W-1:0]   acc_re [1:3];
  logic signed [ACC_W-1:0]   acc_im [1:3];
  logic signed [CW-1:0]      cx;
  logic signed [CW-1:0]      cy;
  logic signed [ARG_BIT-1:0] cz;
  logic                      zero_vec;
  logic signed [ARG_BIT-1:0] res_1;
  logic signed [ARG_BIT-1:0] res_2;

  logic signed [WAVE_BIT_WIDTH-1:0] s_i [0:3];
  logic signed [WAVE_BIT_WIDTH-1:0] s_q [0:3];
  logic signed [PW-1:0]             p_re [1:3];
  logic signed [PW-1:0]             p_im [1:3];
  logic                             all_valid;
  logic [1:0]                       ch;
  logic [SW-1:0]                    it_idx;
  logic signed [CW-1:0]             ld_x, ld_y, sh_x, sh_y, it_x, it_y;
  logic signed [ARG_BIT-1:0]        ld_z, it_z, atan_v, res_now;

  function automatic logic signed [ARG_BIT-1:0] atan_lut(input logic [SW-1:0] i);
    logic [31:0] a;
    case (int'(i))
      0:       a = 32'd8192;
      1:       a = 32'd4836;
      2:       a = 32'd2555;
      3:       a = 32'd1297;
      4:       a = 32'd651;
      5:       a = 32'd326;
      6:       a = 32'd163;
      7:       a = 32'd81;
      8:       a = 32'd41;
      9:       a = 32'd20;
      10:      a = 32'd10;
      11:      a = 32'd5;
      12:      a = 32'd3;
      13:      a = 32'd1;
      14:      a = 32'd1;
      default: a = '0;
    endcase
    return ARG_BIT'(((a << ATAN_SL) + ATAN_RND) >> ATAN_SR);
  endfunction

  always_comb begin
    s_i[0] = bus.data_ci_i0;
    s_q[0] = bus.data_ci_q0;
    s_i[1] = bus.data_ci_i1;
    s_q[1] = bus.data_ci_q1;
    s_i[2] = bus.data_ci_i2;
    s_q[2] = bus.data_ci_q2;
    s_i[3] = bus.data_ci_i3;
    s_q[3] = bus.data_ci_q3;
    all_valid = bus.valid_ci_0 & bus.valid_ci_1 & bus.valid_ci_2 & bus.valid_ci_3;

    for (int unsigned k = 1; k < 4; k++) begin
      p_re[k] = PW'(s_i[k]) * PW'(s_i[0]) + PW'(s_q[k]) * PW'(s_q[0]);
      p_im[k] = PW'(s_q[k]) * PW'(s_i[0]) - PW'(s_i[k]) * PW'(s_q[0]);
    end

    case (state)
      VEC2:    ch = 2'd2;
      VEC3:    ch = 2'd3;
      default: ch = 2'd1;
    endcase

    // Fold the left half-plane onto the right by a pi rotation before vectoring.
    ld_x = CW'(acc_re[ch]);
    ld_y = CW'(acc_im[ch]);
    ld_z = '0;
    if (ld_x[CW-1]) begin
      ld_x = -ld_x;
      ld_y = -ld_y;
      ld_z = {1'b1, {(ARG_BIT-1){1'b0}}};
    end

    it_idx = step - 1'b1;
    sh_x   = cx >>> it_idx;
    sh_y   = cy >>> it_idx;
    atan_v = atan_lut(it_idx);
    if (!cy[CW-1]) begin
      it_x = cx + sh_y;
      it_y = cy - sh_x;
      it_z = cz + atan_v;
    end else begin
      it_x = cx - sh_y;
      it_y = cy + sh_x;
      it_z = cz - atan_v;
    end
    res_now = zero_vec ? '0 : -it_z;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      step          <= '0;
      cx            <= '0;
      cy            <= '0;
      cz            <= '0;
      zero_vec      <= 1'b0;
      res_1         <= '0;
      res_2         <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.arg_out_1 <= '0;
      bus.arg_out_2 <= '0;
      bus.arg_out_3 <= '0;
      for (int unsigned k = 1; k < 4; k++) begin
        acc_re[k] <= '0;
        acc_im[k] <= '0;
      end
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int unsigned k = 1; k < 4; k++) begin
              acc_re[k] <= '0;
              acc_im[k] <= '0;
            end
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= ACCUM;
          end
        end

        ACCUM: begin
          if (cnt == N_SAMPLES) begin
            step  <= '0;
            state <= VEC1;
          end else if (all_valid) begin
            for (int unsigned k = 1; k < 4; k++) begin
              acc_re[k] <= acc_re[k] + ACC_W'(p_re[k]);
              acc_im[k] <= acc_im[k] + ACC_W'(p_im[k]);
            end
            cnt <= cnt + 1'b1;
          end
        end

        VEC1, VEC2, VEC3: begin
          if (step == '0) begin
            cx       <= ld_x;
            cy       <= ld_y;
            cz       <= ld_z;
            zero_vec <= (acc_re[ch] == '0) && (acc_im[ch] == '0);
            step     <= step + 1'b1;
          end else begin
            cx <= it_x;
            cy <= it_y;
            cz <= it_z;
            if (step == SW'(ARG_BIT)) begin
              step <= '0;
              case (state)
                VEC1: begin
                  res_1 <= res_now;
                  state <= VEC2;
                end
                VEC2: begin
                  res_2 <= res_now;
                  state <= VEC3;
                end
                default: begin
                  // All three angles publish together so the rotators switch in the same cycle.
                  bus.arg_out_1 <= res_1;
                  bus.arg_out_2 <= res_2;
                  bus.arg_out_3 <= res_now;
                  bus.done      <= 1'b1;
                  bus.busy      <= 1'b0;
                  state         <= IDLE;
                end
              endcase
            end else begin
              step <= step + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
